vga_term_writer: RTL and testbench

- Wishbone bus initiator that turns a byte stream of characters into writes to the text adapter's video RAM.
- Handles CR, LF, BS, FF, line wrap and hardware scrolling, and drives the adapter's cursor address.
- The adapter screen is 80x25. Row 0 (addresses 0-79) is the service/status line and is never touched. The terminal area is rows 1-24 (byte addresses 80-1999).
- Sits between the console UART/CPU byte source and the adapter's Wishbone slave port.

---
 rtl/vga_term_writer.sv | 210 +++++++++++++++++++++
 tb/tb_vga_term_writer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_term_writer.sv
// vga_term_writer: Wishbone initiator that turns a character byte stream into text-adapter
// video RAM writes. It handles CR, LF, BS and FF, wraps long lines, scrolls the terminal
// area (rows FIRST_ROW..LAST_ROW) in hardware and keeps the adapter cursor address current.
// Rows above FIRST_ROW (the status line) are never addressed.
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   wb_adr_o/dat_o/dat_i     byte address, write data, read data
//   wb_cyc_o/stb_o/we_o/sel_o/ack_i  single-transfer Wishbone handshake, byte lanes
//   ch_dat, ch_valid, ch_ready       character input handshake (ready only when idle)
//   cursor                   row*COLS+col of the cursor
//   busy                     high whenever the writer is not idle
module vga_term_writer #(
  parameter logic [15:0] VBASE     = 16'o0,
  parameter int unsigned COLS      = 80,
  parameter int unsigned FIRST_ROW = 1,
  parameter int unsigned LAST_ROW  = 24,
  parameter logic [7:0]  FILL      = 8'h20
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic [7:0]  ch_dat,
  input  logic        ch_valid,
  output logic        ch_ready,
  output logic [12:0] cursor,
  output logic        busy
);

  localparam int unsigned RW = $clog2(LAST_ROW + 1);
  localparam int unsigned CW = $clog2(COLS);

  localparam logic [RW-1:0] ROW_FIRST = RW'(FIRST_ROW);
  localparam logic [RW-1:0] ROW_LAST  = RW'(LAST_ROW);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);

  localparam logic [12:0] COLS_W    = 13'(COLS);
  localparam logic [12:0] HOME      = 13'(FIRST_ROW * COLS);
  localparam logic [12:0] SRC_BASE  = 13'((FIRST_ROW + 1) * COLS);
  localparam logic [12:0] FILL_BASE = 13'(LAST_ROW * COLS);

  // Last word index of each block operation.
  localparam logic [11:0] CLR_LAST  = 12'((LAST_ROW - FIRST_ROW + 1) * COLS / 2 - 1);
  localparam logic [11:0] SCR_LAST  = 12'((LAST_ROW - FIRST_ROW) * COLS / 2 - 1);
  localparam logic [11:0] FILL_LAST = 12'(COLS / 2 - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PUT      = 3'd1;
  localparam logic [2:0] ST_CLEAR    = 3'd2;
  localparam logic [2:0] ST_SCR_RD   = 3'd3;
  localparam logic [2:0] ST_SCR_WR   = 3'd4;
  localparam logic [2:0] ST_SCR_FILL = 3'd5;

  logic [2:0]    state_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [12:0]   cursor_q;
  logic [11:0]   cnt_q;
  logic [7:0]    ch_q;
  logic [15:0]   rd_q;
  logic          wrap_q;   // scroll was caused by a line wrap, so column returns to 0
  logic [12:0]   word_off;

  assign ch_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign cursor   = cursor_q;

  // Word offset for the block operations; CLEAR and SCR_WR both start at the first row.
  always_comb begin
    word_off = HOME + {cnt_q, 1'b0};
    if (state_q == ST_SCR_RD) begin
      word_off = SRC_BASE + {cnt_q, 1'b0};
    end else if (state_q == ST_SCR_FILL) begin
      word_off = FILL_BASE + {cnt_q, 1'b0};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_CLEAR;  // power-on clear starts on the first cycle out of reset
      row_q    <= ROW_FIRST;
      col_q    <= '0;
      cursor_q <= HOME;
      cnt_q    <= '0;
      ch_q     <= '0;
      rd_q     <= '0;
      wrap_q   <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
    end else if (state_q == ST_IDLE) begin
      if (ch_valid) begin
        ch_q <= ch_dat;
        if (ch_dat >= 8'h20) begin
          state_q <= ST_PUT;
        end else begin
          case (ch_dat)
            8'h0D: begin
              col_q    <= '0;
              cursor_q <= cursor_q - 13'(col_q);
            end
            8'h0A: begin
              if (row_q != ROW_LAST) begin
                row_q    <= row_q + 1'b1;
                cursor_q <= cursor_q + COLS_W;
              end else begin
                wrap_q  <= 1'b0;
                cnt_q   <= '0;
                state_q <= ST_SCR_RD;
              end
            end
            8'h08: begin
              if (col_q != '0) begin
                col_q    <= col_q - 1'b1;
                cursor_q <= cursor_q - 13'd1;
              end
            end
            8'h0C: begin
              cnt_q   <= '0;
              state_q <= ST_CLEAR;
            end
            default: ;
          endcase
        end
      end
    end else if (!wb_cyc_o) begin
      // Issue the next transfer; reached only after at least one cycle with cyc low.
      wb_cyc_o <= 1'b1;
      wb_stb_o <= 1'b1;
      wb_we_o  <= (state_q != ST_SCR_RD);
      if (state_q == ST_PUT) begin
        wb_adr_o <= VBASE + {3'b000, cursor_q};
        wb_dat_o <= {ch_q, ch_q};
        wb_sel_o <= cursor_q[0] ? 2'b10 : 2'b01;
      end else begin
        wb_adr_o <= VBASE + {3'b000, word_off};
        wb_dat_o <= (state_q == ST_SCR_WR) ? rd_q : {FILL, FILL};
        wb_sel_o <= 2'b11;
      end
    end else if (wb_ack_i) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      case (state_q)
        ST_PUT: begin
          if (col_q != COL_LAST) begin
            col_q    <= col_q + 1'b1;
            cursor_q <= cursor_q + 13'd1;
            state_q  <= ST_IDLE;
          end else if (row_q != ROW_LAST) begin
            col_q    <= '0;
            row_q    <= row_q + 1'b1;
            cursor_q <= cursor_q + 13'd1;
            state_q  <= ST_IDLE;
          end else begin
            wrap_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_SCR_RD;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == CLR_LAST) begin
            row_q    <= ROW_FIRST;
            col_q    <= '0;
            cursor_q <= HOME;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        ST_SCR_RD: begin
          rd_q    <= wb_dat_i;
          state_q <= ST_SCR_WR;
        end
        ST_SCR_WR: begin
          if (cnt_q == SCR_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_SCR_FILL;
          end else begin
            cnt_q   <= cnt_q + 12'd1;
            state_q <= ST_SCR_RD;
          end
        end
        ST_SCR_FILL: begin
          if (cnt_q == FILL_LAST) begin
            row_q   <= ROW_LAST;
            state_q <= ST_IDLE;
            if (wrap_q) begin
              col_q    <= '0;
              cursor_q <= FILL_BASE;
            end
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_term_writer.sv
// Self-checking bench for vga_term_writer: a Wishbone slave with byte memory and a
// transaction log, a screen-level reference model (array + row/col), directed tests for
// init, put, control codes, stalled ack, wrap/scroll and reset mid-scroll, then random text.
module tb_vga_term_writer;

  typedef struct packed {
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] wb_adr_o, wb_dat_o;
  logic [15:0] wb_dat_i = '0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [1:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0;
  logic [7:0]  ch_dat = '0;
  logic        ch_valid = 1'b0;
  logic        ch_ready;
  logic [12:0] cursor;
  logic        busy;

  always #5 clk = ~clk;

  vga_term_writer dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_sel_o (wb_sel_o),
    .wb_ack_i (wb_ack_i),
    .ch_dat   (ch_dat),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .cursor   (cursor),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- Wishbone slave: byte memory, programmable ack delay, log ----------
  int         ack_delay = 1;
  int         wcnt = 0;
  logic [7:0] smem [0:2047];
  txn_t       log_q [$];

  function automatic txn_t mk_txn(input logic we, input logic [15:0] adr,
                                  input logic [15:0] dat, input logic [1:0] sel);
    txn_t t;
    t.we = we; t.adr = adr; t.dat = dat; t.sel = sel;
    return t;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      wb_ack_i <= 1'b0;
      wcnt     <= 0;
    end else if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
      if (wcnt >= ack_delay - 1) begin
        wcnt     <= 0;
        wb_ack_i <= 1'b1;
        if (wb_we_o) begin
          if (wb_sel_o[0]) smem[{wb_adr_o[10:1], 1'b0}] <= wb_dat_o[7:0];
          if (wb_sel_o[1]) smem[{wb_adr_o[10:1], 1'b1}] <= wb_dat_o[15:8];
          log_q.push_back(mk_txn(1'b1, wb_adr_o, wb_dat_o, wb_sel_o));
        end else begin
          wb_dat_i <= {smem[{wb_adr_o[10:1], 1'b1}], smem[{wb_adr_o[10:1], 1'b0}]};
          log_q.push_back(mk_txn(1'b0, wb_adr_o,
                                 {smem[{wb_adr_o[10:1], 1'b1}], smem[{wb_adr_o[10:1], 1'b0}]},
                                 wb_sel_o));
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wb_ack_i <= 1'b0;
    end
  end

  // ---------------- Protocol monitor: counts violations, checked from the main flow ----
  int          mon_bad = 0;
  logic        p_cyc = 1'b0, p_ack = 1'b0;
  logic [34:0] p_bus = '0;

  always @(negedge clk) begin
    if (rst) begin
      p_cyc <= 1'b0;
      p_ack <= 1'b0;
    end else begin
      p_cyc <= wb_cyc_o;
      p_ack <= wb_ack_i;
      p_bus <= {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o};
      mon_bad <= mon_bad
               + ((wb_stb_o !== wb_cyc_o) ? 1 : 0)
               + ((wb_cyc_o && ch_ready) ? 1 : 0)
               + ((busy !== !ch_ready) ? 1 : 0)
               + ((p_cyc && p_ack && wb_cyc_o) ? 1 : 0)
               + ((p_cyc && !p_ack && wb_cyc_o &&
                   ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o} !== p_bus)) ? 1 : 0);
    end
  end

  // ---------------- Reference model: screen contents and cursor position ---------------
  logic [7:0] scr [0:2047];
  int m_row = 1;
  int m_col = 0;

  task automatic model_clear();
    for (int i = 80; i < 2000; i++) scr[i] = 8'h20;
    m_row = 1;
    m_col = 0;
  endtask

  task automatic model_scroll();
    for (int i = 80; i < 1920; i++) scr[i] = scr[i + 80];
    for (int i = 1920; i < 2000; i++) scr[i] = 8'h20;
  endtask

  // Returns the number of bus transfers the character should cause.
  task automatic model_char(input logic [7:0] c, output int n);
    n = 0;
    if (c >= 8'h20) begin
      scr[m_row * 80 + m_col] = c;
      n = 1;
      if (m_col < 79) m_col++;
      else begin
        m_col = 0;
        if (m_row < 24) m_row++;
        else begin
          model_scroll();
          n += 1880;
        end
      end
    end else begin
      case (c)
        8'h0D: m_col = 0;
        8'h0A: if (m_row < 24) m_row++; else begin model_scroll(); n = 1880; end
        8'h08: if (m_col > 0) m_col--;
        8'h0C: begin model_clear(); n = 960; end
        default: ;
      endcase
    end
  endtask

  function automatic txn_t get_txn(input int i);
    if (i < log_q.size()) return log_q[i];
    return mk_txn(1'b0, 16'hffff, 16'h0, 2'b00);
  endfunction

  // ---------------- Stimulus helpers ---------------------------------------------------
  task automatic wait_ready(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ch_ready && n < budget);
    check_eq("ready_within_budget", ch_ready, 1'b1);
  endtask

  task automatic send_char(input logic [7:0] c);
    ch_dat   = c;
    ch_valid = 1'b1;
    @(posedge clk);
    #1 ch_valid = 1'b0;
  endtask

  task automatic do_char(input logic [7:0] c, output int lo, output int w);
    int n;
    model_char(c, n);
    lo = log_q.size();
    send_char(c);
    wait_ready(20000, w);
    check_eq("txn_count", log_q.size() - lo, n);
    check_eq("cursor", cursor, m_row * 80 + m_col);
  endtask

  task automatic check_mem();
    int bad = 0;
    for (int i = 0; i < 2048; i++) if (smem[i] !== scr[i]) bad++;
    check_eq("screen_bytes_mismatched", bad, 0);
  endtask

  task automatic check_clear_log(input int lo);
    int bad = 0;
    txn_t t;
    for (int i = 0; i < 960; i++) begin
      t = get_txn(lo + i);
      if (!(t.we && t.sel == 2'b11 && t.dat == 16'h2020 && t.adr == 16'(80 + 2 * i))) bad++;
    end
    check_eq("clear_seq_bad", bad, 0);
  endtask

  task automatic check_scroll_log(input int lo);
    int bad = 0;
    txn_t r, w;
    for (int k = 0; k < 920; k++) begin
      r = get_txn(lo + 2 * k);
      w = get_txn(lo + 2 * k + 1);
      if (r.we || r.adr != 16'(160 + 2 * k)) bad++;
      if (!w.we || w.sel != 2'b11 || w.adr != 16'(80 + 2 * k) || w.dat != r.dat) bad++;
    end
    for (int k = 0; k < 40; k++) begin
      w = get_txn(lo + 1840 + k);
      if (!(w.we && w.sel == 2'b11 && w.dat == 16'h2020 && w.adr == 16'(1920 + 2 * k))) bad++;
    end
    check_eq("scroll_seq_bad", bad, 0);
  endtask

  // ---------------- Main sequence ------------------------------------------------------
  initial begin
    int   lo, w, cyc_n, r;
    txn_t t;
    logic [7:0] c;

    // Reset state and power-on clear.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cyc", wb_cyc_o, 1'b0);
    check_eq("rst_stb", wb_stb_o, 1'b0);
    check_eq("rst_we", wb_we_o, 1'b0);
    check_eq("rst_sel", wb_sel_o, 2'b00);
    check_eq("rst_adr", wb_adr_o, 16'h0);
    check_eq("rst_dat", wb_dat_o, 16'h0);
    check_eq("rst_ready", ch_ready, 1'b0);
    check_eq("rst_cursor", cursor, 13'd80);
    lo  = log_q.size();
    rst = 1'b0;
    model_clear();
    wait_ready(20000, w);
    check_eq("init_txns", log_q.size() - lo, 960);
    check_clear_log(lo);
    check_eq("init_cursor", cursor, 13'd80);
    check_mem();

    // Single puts.
    do_char(8'h41, lo, w);
    t = get_txn(lo);
    check_eq("put_a_adr", t.adr, 16'd80);
    check_eq("put_a_sel", t.sel, 2'b01);
    check_eq("put_a_dat", t.dat, 16'h4141);
    check_eq("put_a_we", t.we, 1'b1);
    do_char(8'h42, lo, w);
    t = get_txn(lo);
    check_eq("put_b_adr", t.adr, 16'd81);
    check_eq("put_b_sel", t.sel, 2'b10);
    check_eq("put_b_dat", t.dat, 16'h4242);
    do_char(8'h43, lo, w);
    check_eq("cursor_after_3", cursor, 13'd83);

    // CR, BS at column 0, discarded control code.
    do_char(8'h0D, lo, w);
    check_eq("cr_cursor", cursor, 13'd80);
    do_char(8'h08, lo, w);
    check_eq("bs_col0_cursor", cursor, 13'd80);
    do_char(8'h07, lo, w);
    check_eq("bel_ready_latency", w, 1);
    check_mem();

    // Stalled ack on a put.
    ack_delay = 5;
    model_char(8'h5A, r);
    lo    = log_q.size();
    cyc_n = 0;
    send_char(8'h5A);
    for (int i = 0; i < 100 && !ch_ready; i++) begin
      @(negedge clk);
      if (wb_cyc_o) cyc_n++;
    end
    check_eq("stall_cyc_cycles", cyc_n, 6);
    check_eq("stall_txns", log_q.size() - lo, r);
    check_eq("stall_cursor", cursor, 13'd81);
    check_eq("stall_protocol", mon_bad, 0);
    ack_delay = 1;

    // Walk down to the last row, fill it, wrap and scroll.
    do_char(8'h0D, lo, w);
    for (int i = 0; i < 23; i++) do_char(8'h0A, lo, w);
    check_eq("row24_cursor", cursor, 13'd1920);
    for (int i = 0; i < 80; i++) do_char(8'($urandom_range(32, 126)), lo, w);
    t = get_txn(lo);
    check_eq("wrap_put_adr", t.adr, 16'd1999);
    check_eq("wrap_put_sel", t.sel, 2'b10);
    check_eq("scr_first_rd", get_txn(lo + 1).adr, 16'd160);
    check_eq("scr_first_wr", get_txn(lo + 2).adr, 16'd80);
    check_eq("scr_last_rd", get_txn(lo + 1839).adr, 16'd1998);
    check_eq("scr_last_wr", get_txn(lo + 1840).adr, 16'd1918);
    check_eq("fill_first", get_txn(lo + 1841).adr, 16'd1920);
    check_eq("fill_last", get_txn(lo + 1880).adr, 16'd1998);
    check_scroll_log(lo + 1);
    check_eq("scroll_cursor", cursor, 13'd1920);
    check_mem();

    // Explicit LF on the last row scrolls and keeps the column.
    do_char(8'h61, lo, w);
    do_char(8'h0A, lo, w);
    check_scroll_log(lo);
    check_eq("lf_scroll_cursor", cursor, 13'd1921);
    check_mem();

    // Reset in the middle of a scroll write.
    lo = log_q.size();
    send_char(8'h0A);
    cyc_n = 0;
    while (cyc_n < 2000 && !(log_q.size() - lo >= 11 && wb_stb_o && wb_we_o)) begin
      @(negedge clk);
      cyc_n++;
    end
    check_eq("midscroll_write_seen", wb_stb_o && wb_we_o, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_cyc", wb_cyc_o, 1'b0);
    check_eq("midrst_stb", wb_stb_o, 1'b0);
    check_eq("midrst_cursor", cursor, 13'd80);
    check_eq("midrst_ready", ch_ready, 1'b0);
    rst = 1'b0;
    model_clear();
    lo = log_q.size();
    wait_ready(20000, w);
    check_eq("reclear_txns", log_q.size() - lo, 960);
    check_clear_log(lo);
    check_mem();

    // Random text with random ack latency.
    for (int i = 0; i < 120; i++) begin
      ack_delay = $urandom_range(1, 3);
      r = $urandom_range(0, 99);
      if (r < 78) c = 8'($urandom_range(32, 255));
      else if (r < 84) c = 8'h0D;
      else if (r < 90) c = 8'h0A;
      else if (r < 95) c = 8'h08;
      else if (r < 97) c = 8'h0C;
      else begin
        c = 8'($urandom_range(0, 31));
        if (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D) c = 8'h1B;
      end
      do_char(c, lo, w);
      check_mem();
    end

    check_eq("bus_protocol_violations", mon_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
